controle_ula: RTL and testbench
===============================

Name: controle_ula

Overview:
Sequencer for the 8-bit ALU datapath. It accepts one operation request at a time over a valid/ready handshake and registers the operands (operand-register stage). It selects the operation, runs it (one cycle for ADD/SUB/AND/OR/XOR, eight iterative shift-add cycles for MUL) and holds a registered result with flags until the consumer takes it. It sits between the instruction/command source and the result register bank.

Parameters:
WIDTH, 8, operand width in bits; result width is 2*WIDTH; MUL iteration count equals WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_opcode  input  3  operation select
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_s  output  2*WIDTH  result
resp_carry  output  1  ADD carry-out / SUB borrow
resp_zero  output  1  resp_s == 0
resp_err  output  1  illegal opcode
busy  output  1  state != OCIOSO

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=OCIOSO, req_ready=1, resp_valid=0, resp_s=0, resp_carry=0, resp_zero=0, resp_err=0, busy=0, iteration counter=0.
- Reset mid-operation: abort on the next edge, discard the in-flight request and any pending result, and return to reset values. rst has priority over every other event.
- Opcodes:
  - 000 ADD: {carry,s[7:0]}=a+b.
  - 001 SUB: s[7:0]=a-b mod 256; carry=1 iff a<b.
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 MUL: s=a*b unsigned, 16 bits; carry=0.
  - 110/111: illegal; s=0, carry=0, zero=1, err=1.
  - For all non-MUL ops, s[15:8]=0.
- States:
  - OCIOSO: req_ready=1. If req_valid, latch opcode/a/b on that edge and go to CARGA.
  - CARGA: one cycle, operands stable in registers. Non-MUL goes to EXEC. MUL clears the accumulator and counter, then goes to MULT.
  - EXEC: one cycle; result and flags registered at the end of the cycle, then go to PRONTO.
  - MULT: each cycle, if b[count]=1 then acc += a<<count; count increments. After the count=WIDTH-1 cycle, register the result and go to PRONTO.
  - PRONTO: resp_valid=1, resp_* stable. If resp_ready is high on an edge, clear resp_valid and go to OCIOSO. Otherwise hold indefinitely.
- Latency, with request accepted on edge k:
  - Non-MUL: resp_valid high after edge k+2.
  - MUL: resp_valid high after edge k+1+WIDTH (k+9 for WIDTH=8).
- req_ready is low in every state except OCIOSO. req_valid outside OCIOSO is ignored; the requester must hold it.
- No bypass: a request cannot be accepted on the same edge a response is consumed. The minimum spacing between acceptances is 4 edges for non-MUL ops.
- resp_s/flags keep their last values after consumption until the next result is registered; only resp_valid drops.
- resp_zero is computed over all 2*WIDTH bits of resp_s.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL.
  - State encoding: OCIOSO, CARGA, EXEC, MULT, PRONTO.
- One sub-module, ula_comb: combinational single-cycle ops (inputs a, b, opcode; outputs s[WIDTH:0], err). It is reused for the MUL accumulate add.
- The FSM, operand registers, accumulator and handshake live in controle_ula.

Test Plan:
- Reset then ADD a=200, b=100, resp_ready=1 -> resp_valid after edge k+2; resp_s=0x002C, carry=1, zero=0, err=0; req_ready returns 1 one edge later.
- SUB a=5, b=9 -> resp_s=0x00FC, carry=1. Then SUB a=9, b=9 -> resp_s=0, carry=0, zero=1.
- MUL a=255, b=255 -> resp_valid exactly after edge k+9; resp_s=0xFE01. MUL a=0, b=77 -> resp_s=0, zero=1.
- AND 0xF0/0x3C -> 0x0030; OR -> 0x00FC; XOR -> 0x00CC. Opcode 111 -> err=1, resp_s=0, zero=1.
- Back-pressure: resp_ready=0 for 10 cycles in PRONTO -> resp_valid and resp_s stable, req_ready=0, a new req_valid is ignored. Raising resp_ready -> single consumption, then the new request is accepted.
- rst asserted during MULT cycle 4 -> next edge all outputs at reset values. A following ADD 1+1 -> resp_s=2, with no residue from the aborted MUL.

Source files
------------

// File: rtl/controle_ula_pkg.sv
// Shared definitions for the ALU sequencer: opcode values and FSM state encoding.
package controle_ula_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   typedef enum logic [2:0] {
      OCIOSO,
      CARGA,
      EXEC,
      MULT,
      PRONTO
   } state_t;

endpackage

// File: rtl/controle_ula_comb.sv
// Single-cycle ALU ops; s[WIDTH] is ADD carry-out or SUB borrow.
// Purely combinational; MUL yields zero here and is sequenced by the controller.
module ula_comb
   import controle_ula_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic [WIDTH:0]   s,
   output logic             err
);

   always_comb begin
      s   = '0;
      err = 1'b0;
      case (opcode)
         OP_ADD: s = {1'b0, a} + {1'b0, b};
         // Bit WIDTH of the widened difference is set exactly when a < b.
         OP_SUB: s = {1'b0, a} - {1'b0, b};
         OP_AND: s = {1'b0, a & b};
         OP_OR:  s = {1'b0, a | b};
         OP_XOR: s = {1'b0, a ^ b};
         OP_MUL: s = '0;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/controle_ula.sv
// ALU sequencer: accepts one request, runs it (2 edges non-MUL, WIDTH+1 edges MUL) and
// holds the registered result until resp_ready; req_ready is low everywhere but OCIOSO.
module controle_ula
   import controle_ula_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_opcode,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [2*WIDTH-1:0] resp_s,
   output logic               resp_carry,
   output logic               resp_zero,
   output logic               resp_err,
   output logic               busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             r_state;
   state_t             w_next;
   logic [2:0]         r_opcode;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_resp_s;
   logic               r_carry;
   logic               r_zero;
   logic               r_err;

   logic [WIDTH-1:0]   w_op_a;
   logic [WIDTH-1:0]   w_op_b;
   logic [2:0]         w_opc;
   logic [WIDTH:0]     w_s;
   logic               w_err;
   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_last;

   // During MULT the ALU adds the multiplicand into the upper half of the product register.
   assign w_op_a = (r_state == MULT) ? r_acc[2*WIDTH-1:WIDTH] : r_a;
   assign w_op_b = r_a;
   assign w_opc  = (r_state == MULT) ? OP_ADD : r_opcode;

   ula_comb #(.WIDTH(WIDTH)) u_ula (
      .a      (w_op_a),
      .b      (w_op_b == r_a && r_state != MULT ? r_b : w_op_b),
      .opcode (w_opc),
      .s      (w_s),
      .err    (w_err)
   );

   // Low half starts as the multiplier; each step tests its lsb and shifts the product in.
   assign w_acc_next = r_acc[0] ? {w_s, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= OCIOSO;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         OCIOSO: if (req_valid) w_next = CARGA;
         CARGA:  w_next = (r_opcode == OP_MUL) ? MULT : EXEC;
         EXEC:   w_next = PRONTO;
         MULT:   if (w_last) w_next = PRONTO;
         PRONTO: if (resp_ready) w_next = OCIOSO;
         default: w_next = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_resp_s <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            OCIOSO: if (req_valid) begin
               r_opcode <= req_opcode;
               r_a      <= req_a;
               r_b      <= req_b;
            end
            CARGA: if (r_opcode == OP_MUL) begin
               r_acc <= {{WIDTH{1'b0}}, r_b};
               r_cnt <= '0;
            end
            EXEC: begin
               r_resp_s <= {{WIDTH{1'b0}}, w_s[WIDTH-1:0]};
               r_carry  <= w_s[WIDTH];
               r_zero   <= (w_s[WIDTH-1:0] == '0);
               r_err    <= w_err;
            end
            MULT: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_resp_s <= w_acc_next;
                  r_carry  <= 1'b0;
                  r_zero   <= (w_acc_next == '0);
                  r_err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (r_state == OCIOSO);
   assign resp_valid = (r_state == PRONTO);
   assign busy       = (r_state != OCIOSO);
   assign resp_s     = r_resp_s;
   assign resp_carry = r_carry;
   assign resp_zero  = r_zero;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_controle_ula.sv
// Directed-vector bench for controle_ula with hand-computed expected results.
module tb_controle_ula;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_opcode;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_s;
   logic        resp_carry;
   logic        resp_zero;
   logic        resp_err;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   controle_ula #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_s     (resp_s),
      .resp_carry (resp_carry),
      .resp_zero  (resp_zero),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and return one edge after it was accepted (edge k).
   task automatic start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      req_opcode = op;
      req_a      = a;
      req_b      = b;
      req_valid  = 1'b1;
      while (!req_ready && n < 40) begin
         tick();
         n++;
      end
      check("accept_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   // Count edges after edge k until resp_valid is seen (bounded).
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [15:0] exp_s,
                        input logic exp_c, input logic exp_z, input logic exp_e);
      int lat;
      start(op, a, b);
      wait_resp(lat);
      check({tag, "_lat"},   lat, exp_lat);
      check({tag, "_s"},     {16'd0, resp_s}, {16'd0, exp_s});
      check({tag, "_carry"}, {31'd0, resp_carry}, {31'd0, exp_c});
      check({tag, "_zero"},  {31'd0, resp_zero}, {31'd0, exp_z});
      check({tag, "_err"},   {31'd0, resp_err}, {31'd0, exp_e});
      tick();
      check({tag, "_consumed"}, {30'd0, resp_valid, req_ready}, 32'b01);
   endtask

   initial begin
      int lat;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_opcode = 3'b000;
      req_a      = 8'd0;
      req_b      = 8'd0;
      resp_ready = 1'b1;
      tick();
      tick();
      check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_busy",       {31'd0, busy}, 32'd0);
      check("rst_outputs",    {13'd0, resp_s, resp_carry, resp_zero, resp_err}, 32'd0);
      rst = 1'b0;

      do_op("add",    3'b000, 8'd200, 8'd100, 2, 16'h002C, 1'b1, 1'b0, 1'b0);
      do_op("sub_b",  3'b001, 8'd5,   8'd9,   2, 16'h00FC, 1'b1, 1'b0, 1'b0);
      do_op("sub_eq", 3'b001, 8'd9,   8'd9,   2, 16'h0000, 1'b0, 1'b1, 1'b0);
      do_op("mul_ff", 3'b101, 8'd255, 8'd255, 9, 16'hFE01, 1'b0, 1'b0, 1'b0);
      do_op("mul_0",  3'b101, 8'd0,   8'd77,  9, 16'h0000, 1'b0, 1'b1, 1'b0);
      do_op("mul_13", 3'b101, 8'd13,  8'd11,  9, 16'h008F, 1'b0, 1'b0, 1'b0);
      do_op("and",    3'b010, 8'hF0,  8'h3C,  2, 16'h0030, 1'b0, 1'b0, 1'b0);
      do_op("or",     3'b011, 8'hF0,  8'h3C,  2, 16'h00FC, 1'b0, 1'b0, 1'b0);
      do_op("xor",    3'b100, 8'hF0,  8'h3C,  2, 16'h00CC, 1'b0, 1'b0, 1'b0);
      do_op("ill7",   3'b111, 8'h12,  8'h34,  2, 16'h0000, 1'b0, 1'b1, 1'b1);
      do_op("ill6",   3'b110, 8'hFF,  8'h01,  2, 16'h0000, 1'b0, 1'b1, 1'b1);
      do_op("add_ff", 3'b000, 8'hFF,  8'h01,  2, 16'h0000, 1'b1, 1'b1, 1'b0);

      // Back-pressure: hold the result while a new request waits.
      resp_ready = 1'b0;
      start(3'b000, 8'd3, 8'd4);
      wait_resp(lat);
      check("bp_lat", lat, 2);
      req_opcode = 3'b000;
      req_a      = 8'd10;
      req_b      = 8'd20;
      req_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", {14'd0, resp_valid, req_ready, resp_s}, {14'd0, 1'b1, 1'b0, 16'd7});
         tick();
      end
      resp_ready = 1'b1;
      tick();
      check("bp_release", {14'd0, resp_valid, req_ready, resp_s}, {14'd0, 1'b0, 1'b1, 16'd7});
      tick();
      req_valid = 1'b0;
      check("bp_accept", {30'd0, busy, req_ready}, 32'b10);
      wait_resp(lat);
      check("bp_new_lat", lat, 2);
      check("bp_new_s", {16'd0, resp_s}, 32'd30);
      tick();
      check("bp_single", {30'd0, resp_valid, req_ready}, 32'b01);

      // Reset during the fourth MULT cycle.
      start(3'b101, 8'd255, 8'd255);
      for (int i = 0; i < 4; i++) tick();
      check("abort_in_mult", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      check("abort_ready", {30'd0, req_ready, resp_valid}, 32'b10);
      check("abort_busy",  {31'd0, busy}, 32'd0);
      check("abort_outs",  {13'd0, resp_s, resp_carry, resp_zero, resp_err}, 32'd0);
      rst = 1'b0;
      do_op("post_add", 3'b000, 8'd1, 8'd1, 2, 16'h0002, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
